// File: rtl/pwm_ctrl_pkg.sv
// Shared encodings, default parameters and payload types for the PWM bank controller.
package pwm_ctrl_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned DEF_NUM_CH       = 8;
  localparam int unsigned DEF_FRAME_CYC    = 400000;
  localparam int unsigned DEF_WDOG_FRAMES  = 100;
  localparam int unsigned DEF_FS_HI        = 100000;

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_PENDING  = 2'd2;
  localparam logic [1:0] ST_FAILSAFE = 2'd3;

  // One channel's configuration, used for both shadow and active copies.
  typedef struct packed {
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] hi;
  } ch_cfg_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running frame counter; frame_tick marks the last cycle of each frame.
module pwm_frame_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_CYC = DEF_FRAME_CYC
) (
  input  logic clk,
  input  logic reset_n,
  output logic frame_tick
);

  localparam int unsigned   CNT_W = idx_width(FRAME_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             run_q;

  // The first edge after reset loads count 0; counting proper starts after that.
  always_comb begin
    cnt_nxt = '0;
    if (run_q && (cnt_q != LAST)) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      run_q      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt_q      <= cnt_nxt;
      run_q      <= 1'b1;
      frame_tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/pwm_bank_ctrl.sv
// PWM bank controller: shadowed channel config, frame-aligned atomic commit,
// arm gating and a frame watchdog that drops all channels into failsafe.
module pwm_bank_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned FRAME_CYC   = DEF_FRAME_CYC,
  parameter int unsigned WDOG_FRAMES = DEF_WDOG_FRAMES,
  parameter int unsigned FS_HI       = DEF_FS_HI,
  localparam int unsigned CH_W       = idx_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     arm,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [DATA_W-1:0]        cfg_period,
  input  logic [DATA_W-1:0]        cfg_hi,
  input  logic                     commit,
  output logic [DATA_W*NUM_CH-1:0] ch_period,
  output logic [DATA_W*NUM_CH-1:0] ch_hi,
  output logic [1:0]               state,
  output logic                     commit_done,
  output logic                     frame_tick,
  output logic                     err
);

  localparam int unsigned      WD_W    = idx_width(WDOG_FRAMES + 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WDOG_FRAMES);
  localparam logic [DATA_W-1:0] FS_HI_V = DATA_W'(FS_HI);

  ch_cfg_t                   shadow_q [NUM_CH];
  ch_cfg_t                   act_q    [NUM_CH];
  logic [1:0]                state_q;
  logic [1:0]                state_nxt;
  logic [WD_W-1:0]           wd_q;
  logic [WD_W-1:0]           wd_nxt;
  logic [WD_W-1:0]           wd_inc_c;
  logic                      apply_c;
  logic                      wr_c;
  logic                      wr_ok_c;
  logic [DATA_W*NUM_CH-1:0]  ch_hi_nxt;

  pwm_frame_timer #(
    .FRAME_CYC (FRAME_CYC)
  ) u_frame_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick)
  );

  assign state = state_q;

  // Next state, watchdog and apply decision.
  always_comb begin
    state_nxt = state_q;
    wd_nxt    = wd_q;
    apply_c   = 1'b0;
    wr_c      = cfg_valid && cfg_ready;
    wr_ok_c   = wr_c && (32'(cfg_ch) < NUM_CH);
    wd_inc_c  = (wd_q < WD_MAX) ? (wd_q + WD_W'(1)) : wd_q;

    if (!arm) begin
      state_nxt = ST_DISARMED;
      wd_nxt    = '0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          state_nxt = ST_ARMED;
          wd_nxt    = '0;
        end
        ST_ARMED: begin
          if (frame_tick) begin
            wd_nxt = wd_inc_c;
          end
          // A fresh commit takes precedence over a watchdog expiry on the same tick.
          if (commit) begin
            state_nxt = ST_PENDING;
          end else if (frame_tick && (wd_inc_c >= WD_MAX)) begin
            state_nxt = ST_FAILSAFE;
          end
        end
        ST_PENDING: begin
          if (frame_tick) begin
            apply_c   = 1'b1;
            wd_nxt    = '0;
            state_nxt = ST_ARMED;
          end
        end
        default: begin
          if (commit) begin
            state_nxt = ST_PENDING;
          end
        end
      endcase
    end
  end

  // Output high-times follow the state being entered so they line up with state.
  always_comb begin
    ch_hi_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_nxt == ST_FAILSAFE) begin
        ch_hi_nxt[DATA_W*i +: DATA_W] = FS_HI_V;
      end else if (state_nxt != ST_DISARMED) begin
        ch_hi_nxt[DATA_W*i +: DATA_W] = apply_c ? shadow_q[i].hi : act_q[i].hi;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_DISARMED;
      wd_q        <= '0;
      cfg_ready   <= 1'b0;
      commit_done <= 1'b0;
      err         <= 1'b0;
      ch_hi       <= '0;
    end else begin
      state_q     <= state_nxt;
      wd_q        <= wd_nxt;
      cfg_ready   <= (state_nxt != ST_PENDING);
      commit_done <= apply_c;
      ch_hi       <= ch_hi_nxt;
      if (wr_c && !wr_ok_c) begin
        err <= 1'b1;
      end
    end
  end

  // Shadow writes and the atomic shadow-to-active transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        act_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (apply_c) begin
          act_q[i] <= shadow_q[i];
        end
        if (wr_ok_c && (cfg_ch == CH_W'(i))) begin
          shadow_q[i] <= '{period: cfg_period, hi: cfg_hi};
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign ch_period[DATA_W*g +: DATA_W] = act_q[g].period;
  end

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Randomised bench for pwm_bank_ctrl with a frame-level reference model and directed corner cases.
module tb_pwm_bank_ctrl;

  localparam int unsigned NCH = 6;
  localparam int unsigned FC  = 20;
  localparam int unsigned WD  = 3;
  localparam int unsigned FSH = 77;
  localparam int unsigned CW  = 3;
  localparam int unsigned VW  = 32 * NCH;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          commit = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [31:0]   cfg_period = '0;
  logic [31:0]   cfg_hi = '0;
  logic          cfg_ready, commit_done, frame_tick, err;
  logic [VW-1:0] ch_period, ch_hi;
  logic [1:0]    state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pwm_bank_ctrl #(
    .NUM_CH      (NCH),
    .FRAME_CYC   (FC),
    .WDOG_FRAMES (WD),
    .FS_HI       (FSH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .arm         (arm),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_hi      (cfg_hi),
    .commit      (commit),
    .ch_period   (ch_period),
    .ch_hi       (ch_hi),
    .state       (state),
    .commit_done (commit_done),
    .frame_tick  (frame_tick),
    .err         (err)
  );

  // Reference model: frame position counted from reset release, plain arrays for shadows.
  int          m_state, m_wd, m_pos;
  bit          m_ready, m_err, m_done;
  logic [31:0] sh_p [NCH];
  logic [31:0] sh_h [NCH];
  logic [31:0] ac_p [NCH];
  logic [31:0] ac_h [NCH];

  task automatic reset_model();
    m_state = 0; m_wd = 0; m_pos = -1;
    m_ready = 0; m_err = 0; m_done = 0;
    for (int i = 0; i < NCH; i++) begin
      sh_p[i] = '0; sh_h[i] = '0; ac_p[i] = '0; ac_h[i] = '0;
    end
  endtask

  task automatic step_model();
    bit tick;
    bit wr;
    int ns;
    tick   = (m_pos == int'(FC) - 1);
    wr     = cfg_valid && m_ready;
    ns     = m_state;
    m_done = 0;
    if (!arm) ns = 0;
    else if (m_state == 0) begin ns = 1; m_wd = 0; end
    else if (m_state == 1) begin
      if (tick && m_wd < int'(WD)) m_wd++;
      if (commit) ns = 2;
      else if (tick && m_wd >= int'(WD)) ns = 3;
    end else if (m_state == 2) begin
      if (tick) begin
        for (int i = 0; i < NCH; i++) begin ac_p[i] = sh_p[i]; ac_h[i] = sh_h[i]; end
        m_done = 1; m_wd = 0; ns = 1;
      end
    end else if (commit) ns = 2;
    if (wr) begin
      if (int'(cfg_ch) < int'(NCH)) begin
        sh_p[int'(cfg_ch)] = cfg_period;
        sh_h[int'(cfg_ch)] = cfg_hi;
      end else m_err = 1;
    end
    m_state = ns;
    m_pos   = (m_pos + 1) % int'(FC);
    m_ready = (ns != 2);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) reset_model();
    else step_model();
  end

  function automatic logic [VW-1:0] exp_hi();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++)
      v[32*i +: 32] = (m_state == 0) ? 32'd0 : (m_state == 3) ? 32'(FSH) : ac_h[i];
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_period();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[32*i +: 32] = ac_p[i];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("state", VW'(state), VW'(m_state));
      chk("cfg_ready", VW'(cfg_ready), VW'(m_ready));
      chk("err", VW'(err), VW'(m_err));
      chk("commit_done", VW'(commit_done), VW'(m_done));
      chk("frame_tick", VW'(frame_tick), VW'(m_pos == int'(FC) - 1));
      chk("ch_period", ch_period, exp_period());
      chk("ch_hi", ch_hi, exp_hi());
    end
  end

  task automatic step_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!commit_done && n < 3 * int'(FC)) begin step_cyc(); n++; end
    if (!commit_done) begin
      vectors++; miscompares++;
      $display("FAIL %s: commit_done not seen within %0d cycles, required a pulse", nm, n);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!frame_tick && n < 3 * int'(FC)) begin step_cyc(); n++; end
    if (!frame_tick) begin
      vectors++; miscompares++;
      $display("FAIL wait_tick: frame_tick not seen within %0d cycles, required a pulse", n);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_state", VW'(state), VW'(0));
    chk("rst_ch_hi", ch_hi, '0);
    chk("rst_ch_period", ch_period, '0);
    chk("rst_err", VW'(err), VW'(0));
    chk("rst_done", VW'(commit_done), VW'(0));
    chk("rst_tick", VW'(frame_tick), VW'(0));
    chk("rst_ready", VW'(cfg_ready), VW'(0));
    step_cyc();
    step_cyc();
    reset_n = 1'b1;
  endtask

  task automatic write_cfg(input int ch, input int p, input int h);
    cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_period = 32'(p); cfg_hi = 32'(h);
  endtask

  initial begin
    int n;
    logic [VW-1:0] fs_vec;
    reset_model();
    fs_vec = '0;
    for (int i = 0; i < NCH; i++) fs_vec[32*i +: 32] = 32'(FSH);

    step_cyc();
    do_reset();

    // Two channels written, commit shares a cycle with the second write.
    arm = 1'b1;
    step_cyc();
    write_cfg(0, 1000, 250);
    step_cyc();
    write_cfg(3, 2000, 500);
    commit = 1'b1;
    step_cyc();
    cfg_valid = 1'b0; commit = 1'b0;
    wait_done("basic_apply", n);
    chk("ch0_period", VW'(ch_period[31:0]), VW'(1000));
    chk("ch0_hi", VW'(ch_hi[31:0]), VW'(250));
    chk("ch3_period", VW'(ch_period[127:96]), VW'(2000));
    chk("ch3_hi", VW'(ch_hi[127:96]), VW'(500));
    step_cyc();
    chk("done_single", VW'(commit_done), VW'(0));

    // Commit on the tick cycle waits a full frame.
    wait_tick();
    write_cfg(1, 4000, 1234);
    commit = 1'b1;
    step_cyc();
    cfg_valid = 1'b0; commit = 1'b0;
    chk("tick_commit_state", VW'(state), VW'(2));
    chk("tick_commit_ready", VW'(cfg_ready), VW'(0));
    chk("tick_commit_nodone", VW'(commit_done), VW'(0));
    wait_done("tick_commit", n);
    chk("tick_commit_latency", VW'(n), VW'(FC));
    chk("ch1_hi", VW'(ch_hi[63:32]), VW'(1234));

    // Watchdog expiry after three idle frames, then recovery by commit.
    for (int i = 0; i < 3 * int'(FC) - 1; i++) step_cyc();
    chk("wdog_before", VW'(state), VW'(1));
    step_cyc();
    chk("wdog_state", VW'(state), VW'(3));
    chk("wdog_hi", ch_hi, fs_vec);
    chk("wdog_period_hold", VW'(ch_period[31:0]), VW'(1000));
    write_cfg(2, 300, 30);
    commit = 1'b1;
    step_cyc();
    cfg_valid = 1'b0; commit = 1'b0;
    wait_done("fs_recover", n);
    chk("fs_recover_state", VW'(state), VW'(1));
    chk("ch2_hi", VW'(ch_hi[95:64]), VW'(30));
    chk("ch0_hi_kept", VW'(ch_hi[31:0]), VW'(250));

    // Out-of-range channel write.
    write_cfg(int'(NCH), 9999, 9999);
    step_cyc();
    cfg_valid = 1'b0;
    step_cyc();
    chk("err_set", VW'(err), VW'(1));

    // Disarm while pending.
    commit = 1'b1;
    step_cyc();
    commit = 1'b0;
    chk("pend_state", VW'(state), VW'(2));
    arm = 1'b0;
    step_cyc();
    chk("disarm_state", VW'(state), VW'(0));
    chk("disarm_hi", ch_hi, '0);
    chk("disarm_nodone", VW'(commit_done), VW'(0));
    for (int i = 0; i < int'(FC) + 2; i++) step_cyc();
    chk("err_sticky", VW'(err), VW'(1));
    arm = 1'b1;

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      int cpct;
      cpct = ((c / 500) % 2 == 1) ? 8 : 1;
      arm       = ($urandom_range(99) < 97);
      cfg_valid = ($urandom_range(99) < 35);
      cfg_ch    = ($urandom_range(99) < 5) ? CW'(NCH + $urandom_range(1)) : CW'($urandom_range(NCH - 1));
      cfg_period = 32'($urandom_range(5000));
      cfg_hi     = 32'($urandom_range(5000));
      commit     = ($urandom_range(99) < cpct);
      if ($urandom_range(999) == 0) do_reset();
      else step_cyc();
    end
    cfg_valid = 1'b0; commit = 1'b0; arm = 1'b1;

    // Reset mid-frame: first tick exactly one frame after release.
    for (int i = 0; i < 7; i++) step_cyc();
    do_reset();
    n = 0;
    while (!frame_tick && n < 3 * int'(FC)) begin step_cyc(); n++; end
    chk("first_tick_latency", VW'(n), VW'(FC));
    step_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_bank_ctrl.md
PWM_BANK_CTRL -- requirements
Module: pwm_bank_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8: number of PWM channels controlled.
REQ-002 Parameter FRAME_CYC, default 400000: clk cycles per update frame.
REQ-003 Parameter WDOG_FRAMES, default 100: frames without commit before failsafe.
REQ-004 Parameter FS_HI, default 100000: failsafe high-time in clk cycles.
REQ-005 The block SHALL have exactly one clock, clk, and an asynchronous active-low reset, reset_n.
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 arm  in  1  level; 1 enables outputs, 0 forces all ch_hi to 0.
REQ-009 cfg_valid  in  1  shadow-write request.
REQ-010 cfg_ready  out  1  shadow-write accept.
REQ-011 cfg_ch  in  $clog2(NUM_CH)  target channel index.
REQ-012 cfg_period  in  32  requested period, cycles.
REQ-013 cfg_hi  in  32  requested high-time, cycles.
REQ-014 commit  in  1  single-cycle pulse requesting atomic apply of all shadows.
REQ-015 ch_period  out  32*NUM_CH  active periods, channel i at bits [32i+31:32i].
REQ-016 ch_hi  out  32*NUM_CH  active high-times, same packing.
REQ-017 state  out  2  current FSM state encoding.
REQ-018 commit_done  out  1  one-cycle pulse on the cycle active registers update from shadows.
REQ-019 frame_tick  out  1  one-cycle pulse at the last cycle of each frame.
REQ-020 err  out  1  sticky: set on write to out-of-range channel.

Function
REQ-021 Frame counter SHALL count 0..FRAME_CYC-1 and wrap; frame_tick=1 exactly when the count equals FRAME_CYC-1.
REQ-022 FSM states: DISARMED=0, ARMED=1, PENDING=2, FAILSAFE=3.
REQ-023 arm=0 SHALL force DISARMED from any state on the next edge; commit is ignored; ch_hi all 0; ch_period holds.
REQ-024 DISARMED with arm=1 -> ARMED; watchdog count cleared.
REQ-025 cfg_ready SHALL be 1 in DISARMED, ARMED and FAILSAFE, and 0 in PENDING.
REQ-026 cfg_valid&&cfg_ready SHALL write shadow[cfg_ch] with {cfg_period,cfg_hi} on that edge; last write wins.
REQ-027 cfg_ch>=NUM_CH SHALL be accepted, discard the data and set err; err clears only on reset.
REQ-028 commit in ARMED or FAILSAFE -> PENDING; a cfg write in the same cycle as commit SHALL be included in the apply.
REQ-029 In PENDING, at the next frame_tick all NUM_CH active registers SHALL load from shadows on the same edge, commit_done pulses that cycle, watchdog clears, and the next state is ARMED.
REQ-030 A commit coinciding with frame_tick SHALL apply at the following frame_tick, never the same one.
REQ-031 commit in PENDING or DISARMED SHALL be ignored.
REQ-032 The watchdog SHALL increment on each frame_tick in ARMED, saturating; on reaching WDOG_FRAMES -> FAILSAFE.
REQ-033 In FAILSAFE, ch_hi SHALL be FS_HI on every channel and ch_period SHALL hold; shadows remain writable.
REQ-034 Apply and watchdog expiry on the same tick: apply wins, state ARMED.
REQ-035 Outputs are registered; an apply becomes visible on ch_* one cycle after the frame_tick edge.

Reset
REQ-036 Asserting reset_n=0 SHALL immediately clear: shadows, ch_period, ch_hi, frame counter, watchdog, err, commit_done, frame_tick to 0; state to DISARMED; cfg_ready to 0.
REQ-037 Reset mid-PENDING SHALL discard the pending commit; no commit_done follows.
REQ-038 After deassertion, the frame counter starts at 0 on the first clk edge.

Structure
REQ-039 Package pwm_ctrl_pkg SHALL hold the state encodings and default parameter constants.
REQ-040 Sub-module pwm_frame_timer SHALL implement the frame counter and frame_tick.

Verification
REQ-041 Write ch0={1000,250}, ch3={2000,500}, commit -> at the next frame_tick, ch_period[0]=1000, ch_hi[0]=250, ch_period[3]=2000, ch_hi[3]=500 updated in the same cycle; one commit_done pulse.
REQ-042 Commit asserted on the frame_tick cycle -> no update at that tick; update and commit_done at the next tick; cfg_ready=0 in between.
REQ-043 WDOG_FRAMES=3, arm=1, no commit -> state=3 after the 3rd frame_tick, all ch_hi=FS_HI; commit -> ARMED at the next tick with shadow values.
REQ-044 arm dropped during PENDING -> state=0 next cycle, all ch_hi=0, no commit_done.
REQ-045 Write cfg_ch=NUM_CH -> err=1, no shadow changed, err persists until reset_n=0.
REQ-046 reset_n pulsed low mid-frame -> all outputs 0 asynchronously, state=0, frame_tick first at FRAME_CYC cycles after release.
